// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper for a 3-input combinational gate.
// Steps {in1,in2,in3} through 000..111 and holds each combination for
// SETTLE_CYCLES cycles. It then samples the synchronized gate output and
// assembles the 8-bit truth-table word, with combination 000 in bit 7.
// The assembled word is compared against EXPECTED.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,     // 3..255
    parameter logic [7:0]  EXPECTED      = 8'h84
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic       sync1;
    logic       sync2;

    // The gate inputs always come straight from the registered combination index.
    assign {in1, in2, in3} = idx;

    // Two-flop synchronizer for the gate output, which has no timing relation to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1, which forms a real two-stage chain.
            sync1 <= dut_out;
            sync2 <= sync1;
        end
    end

    // Sweep controller: sequencing, settle timing, capture and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= 8'd0;
            match     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort beats a same-cycle start; table_out and match hold until accepted.
                    if (start && !abort) begin
                        table_out <= 8'd0;
                        match     <= 1'b0;
                        idx       <= 3'd0;
                        cnt       <= RELOAD;
                        busy      <= 1'b1;
                        state     <= APPLY;
                    end
                end

                APPLY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        match <= 1'b0;
                        idx   <= 3'd0;
                    end else if (cnt == 8'd0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                SAMPLE: begin
                    // abort suppresses this combination's write, so table_out keeps only earlier bits.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        match <= 1'b0;
                        idx   <= 3'd0;
                    end else begin
                        table_out[3'd7 - idx] <= sync2;
                        if (idx != 3'd7) begin
                            idx   <= idx + 3'd1;
                            cnt   <= RELOAD;
                            state <= APPLY;
                        end else begin
                            // idx 7 is written to bit 0, so compare against the word including this bit.
                            match <= ({table_out[7:1], sync2} == EXPECTED);
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    idx   <= 3'd0;
                    if (abort) begin
                        match <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    idx   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
// The gate under test is modelled as a truth-table word indexed by the combination.
// Expected outputs are derived from cycle position within a sweep.
module tb_truth_table_sweeper;

    localparam int         S   = 4;
    localparam int         P   = S + 1;       // cycles per combination
    localparam int         T   = 8 * P;       // accept edge to DONE entry
    localparam logic [7:0] EXP = 8'h84;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic       in1, in2, in3;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;

    logic [7:0] func;
    logic [7:0] last_tab;
    logic       last_match;
    int         checks = 0;
    int         errors = 0;

    truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .dut_out   (dut_out),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .match     (match)
    );

    always #5 clk = ~clk;

    // Gate model: output for combination c is func[7-c].
    assign dut_out = func[3'd7 - {in1, in2, in3}];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] tab, input logic m);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " inputs"}, 32'({in1, in2, in3}), 32'd0);
        check({tag, " table"}, 32'(table_out), 32'(tab));
        check({tag, " match"}, 32'(match), 32'(m));
    endtask

    // One sweep. abort_at / rst_at are cycle numbers after the accept edge (-1 = none).
    task automatic sweep(input logic [7:0] f, input bit repulse, input int abort_at, input int rst_at);
        logic [7:0] ff = 8'hFF;
        logic [7:0] exp_tab;
        logic [2:0] exp_idx;
        bit         aborted = 1'b0;
        int         n;
        int         n_frozen = 0;
        bit         exp_busy, exp_done, exp_match;
        func = f;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= T + 5; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (!aborted && abort_at >= 0 && k == abort_at + 1) begin
                aborted  = 1'b1;
                n_frozen = abort_at / P;
                abort    = 1'b0;
            end
            n         = aborted ? n_frozen : ((k / P > 8) ? 8 : k / P);
            exp_tab   = f & ~(ff >> n);
            exp_busy  = !aborted && (k <= T);
            exp_done  = !aborted && (k == T);
            exp_match = !aborted && (k >= T) && (f == EXP);
            if (aborted || k > T) exp_idx = 3'd0;
            else if (k == T)      exp_idx = 3'd7;
            else                  exp_idx = 3'(k / P);
            check($sformatf("busy k=%0d", k), 32'(busy), 32'(exp_busy));
            check($sformatf("done k=%0d", k), 32'(done), 32'(exp_done));
            check($sformatf("idx k=%0d", k), 32'({in1, in2, in3}), 32'(exp_idx));
            check($sformatf("table k=%0d", k), 32'(table_out), 32'(exp_tab));
            check($sformatf("match k=%0d", k), 32'(match), 32'(exp_match));
            last_tab   = exp_tab;
            last_match = exp_match;
            start = repulse && (k == 3 || k == 20);
            if (k == abort_at) abort = 1'b1;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_idle("async reset", 8'd0, 1'b0);
                @(posedge clk);
                #1;
                rst        = 1'b0;
                last_tab   = 8'd0;
                last_match = 1'b0;
                check_idle("after reset", 8'd0, 1'b0);
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        func  = 8'h00;
        #1;
        check_idle("reset state", 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("post reset", 8'd0, 1'b0);

        sweep(8'h84, 1'b0, -1, -1);            // matching gate
        sweep(8'h7B, 1'b0, -1, -1);            // complement: no match
        sweep(8'h84, 1'b0, -1, -1);            // clears then matches again
        sweep(8'hFF, 1'b0, -1, -1);            // tied high
        sweep(8'h00, 1'b0, -1, -1);            // tied low
        sweep(8'h84, 1'b1, -1, -1);            // start re-pulsed while busy
        sweep(8'hA6, 1'b0, 4 * P - 1, -1);     // abort in combination 3 SAMPLE
        repeat (3) @(posedge clk);
        #1;
        check_idle("idle after abort", last_tab, last_match);

        // start and abort together in IDLE: no sweep starts.
        sweep(8'h84, 1'b0, -1, -1);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check_idle("start+abort", last_tab, last_match);
        @(posedge clk);
        #1;
        check_idle("start+abort hold", last_tab, last_match);

        sweep(8'hE5, 1'b0, -1, 17);            // reset mid-sweep
        sweep(8'h84, 1'b0, -1, -1);            // full sweep after reset

        for (int i = 0; i < 3; i++) begin
            sweep(8'($urandom), 1'b0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage wrapped around a 3-input combinational logic gate in the Cello 3-input truth-table set.
- Drives in1..in3 through all 8 input combinations and waits a programmable settle time per combination.
- Samples the gate's output after each settle time and assembles the 8-bit truth-table word in the set's hex-naming convention.
- Flags whether the captured word equals an expected function code.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each combination is held before sampling; legal range 3..255.
- EXPECTED, 8'h84, expected truth-table word for the match flag.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- abort  input  1  synchronous sweep cancel.
- dut_out  input  1  output of the gate under test; treated as asynchronous.
- in1  output  1  gate input, MSB of the combination index.
- in2  output  1  gate input, middle bit of the combination index.
- in3  output  1  gate input, LSB of the combination index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  captured truth-table word.
- match  output  1  table_out == EXPECTED, valid after done.

Behaviour:
- Reset (rst high, async): state IDLE; idx=0; in1..in3=0; busy=0; done=0; table_out=0; match=0; synchronizer flops=0.
- dut_out passes through a 2-flop synchronizer before any use.
- {in1,in2,in3} is always driven from the registered 3-bit idx.
- Bit mapping: the sample for combination idx is written to table_out[7-idx].
  - idx 3'b000 -> bit 7; idx 3'b111 -> bit 0.
  - Example: a gate that is high only at 000 and 101 yields 8'h84.
- IDLE:
  - busy=0.
  - start=1 and abort=0: clear table_out and match, set idx=0, load settle counter with SETTLE_CYCLES-1, go to APPLY, set busy=1 on the next cycle.
- APPLY:
  - Counter decrements each cycle.
  - At count 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - table_out[7-idx] <= synchronized dut_out.
  - idx < 7: idx <= idx+1, reload counter, go to APPLY.
  - idx = 7: go to DONE.
- Per combination: SETTLE_CYCLES cycles in APPLY plus 1 in SAMPLE. The 2-flop synchronizer delay is covered because SETTLE_CYCLES >= 3.
- Full sweep: 8*(SETTLE_CYCLES+1) cycles from the start-accept edge to DONE entry.
- DONE (1 cycle):
  - done=1.
  - match <= (table_out final == EXPECTED), including bit 0 captured in the final SAMPLE.
  - busy stays 1 this cycle.
  - Next state IDLE: busy=0, idx=0, in1..in3=0.
- Outputs hold in IDLE: table_out and match keep their values until the next accepted start.
- start while busy: ignored; no restart, no queueing.
- abort in APPLY, SAMPLE or DONE:
  - Next cycle enters IDLE with busy=0, done=0 (no pulse), match=0, idx=0.
  - table_out keeps partial contents.
  - abort has priority over the same-cycle SAMPLE write and over DONE.
- start and abort together in IDLE: abort wins; the sweep does not start.
- rst asserted mid-sweep: immediate return to the reset values above; no done pulse.
- Counter width 8 bits, with no wrap because SETTLE_CYCLES <= 255. idx wrap from 7 never occurs; DONE is entered instead.

Test Plan:
- Model dut_out = (idx==0 || idx==5), SETTLE_CYCLES=4, pulse start -> in sequence 000..111 held 5 cycles each, done pulses at cycle 40 after accept, table_out=8'h84, match=1.
- Model dut_out = ~(idx==0 || idx==5) -> table_out=8'h7B, match=0. Next sweep with the first model -> table_out and match cleared at start, then 8'h84 / 1.
- dut_out tied 1 and tied 0 -> 8'hFF / 8'h00, match=0. busy high for exactly 41 cycles, done high for exactly 1 cycle.
- start re-pulsed at cycles 3 and 20 of an active sweep -> ignored; done still at cycle 40 with a single pulse.
- abort asserted during combination 3's SAMPLE cycle -> bit 4 not written, IDLE next cycle, no done, match=0, bits 7..5 retain captured values.
- rst asserted for 1 cycle at cycle 17 -> all outputs 0 immediately, including table_out. A subsequent start runs a full, correct sweep.
